// File: rtl/ysyx_23060191_ifid_pkg.sv
// Shared IF/ID definitions: datapath width and the buffer occupancy encoding.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package ysyx_23060191_ifid_pkg;

    // Width of the PC and instruction words across the core.
    localparam int CPU_WIDTH = 32;

    // Occupancy of the two-entry IF/ID buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ifid_state_e;

endpackage

// File: rtl/ysyx_23060191_ifid.sv
// Two-entry elastic IF/ID register; ports: fetch side (i_if_valid/o_if_ready, i_pc, i_inst),
// decode side (o_id_valid/i_id_ready, o_pc, o_inst), i_flush redirect, o_fire_cnt handshake count.
// Latency: 1 cycle from enqueue to decode visibility, no bypass. Backpressure: o_if_ready is
// registered from the next occupancy, so decode stalls never reach fetch combinationally.
module ysyx_23060191_ifid #(
    parameter int CPU_WIDTH = ysyx_23060191_ifid_pkg::CPU_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_if_valid,
    output logic                 o_if_ready,
    input  logic [CPU_WIDTH-1:0] i_pc,
    input  logic [CPU_WIDTH-1:0] i_inst,
    input  logic                 i_flush,
    output logic                 o_id_valid,
    input  logic                 i_id_ready,
    output logic [CPU_WIDTH-1:0] o_pc,
    output logic [CPU_WIDTH-1:0] o_inst,
    output logic [31:0]          o_fire_cnt
);
    import ysyx_23060191_ifid_pkg::*;

    ifid_state_e          state_q;
    ifid_state_e          state_d;
    logic                 head_q;
    logic                 tail_q;
    logic                 if_ready_q;
    logic [31:0]          fire_cnt_q;
    logic [CPU_WIDTH-1:0] slot_pc   [2];
    logic [CPU_WIDTH-1:0] slot_inst [2];

    logic enq;
    logic deq;

    // Flush masks both handshakes so a redirect cycle neither accepts nor retires a pair.
    assign enq        = i_if_valid & if_ready_q & ~i_flush;
    assign o_id_valid = (state_q != EMPTY) & ~i_flush;
    assign deq        = o_id_valid & i_id_ready;

    assign o_if_ready = if_ready_q;
    assign o_pc       = slot_pc[head_q];
    assign o_inst     = slot_inst[head_q];
    assign o_fire_cnt = fire_cnt_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (enq) state_d = ONE;
            ONE: begin
                if (enq & ~deq)      state_d = FULL;
                else if (~enq & deq) state_d = EMPTY;
            end
            FULL:    if (deq) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (i_flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= EMPTY;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            if_ready_q <= 1'b0;
            fire_cnt_q <= 32'd0;
            for (int i = 0; i < 2; i++) begin
                slot_pc[i]   <= '0;
                slot_inst[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            // Ready looks one cycle ahead: it reflects the occupancy we are about to enter.
            if_ready_q <= (state_d != FULL);
            if (i_flush) begin
                head_q <= 1'b0;
                tail_q <= 1'b0;
            end else begin
                // Writes only ever land in the tail slot, so the head stays stable under stall.
                if (enq) begin
                    slot_pc[tail_q]   <= i_pc;
                    slot_inst[tail_q] <= i_inst;
                    tail_q            <= ~tail_q;
                end
                if (deq) begin
                    head_q <= ~head_q;
                end
            end
            // deq is already suppressed under flush; the count survives redirects.
            if (deq) begin
                fire_cnt_q <= fire_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060191_ifid.sv
// Self-checking bench for the IF/ID buffer against a queue-based reference model.
// Latency: model expects decode visibility one cycle after acceptance.
// Backpressure: model ready is "fewer than two pairs held after the edge".
module tb_ysyx_23060191_ifid;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } pair_t;

    logic        clk;
    logic        rstn;
    logic        i_if_valid;
    logic        o_if_ready;
    logic [31:0] i_pc;
    logic [31:0] i_inst;
    logic        i_flush;
    logic        o_id_valid;
    logic        i_id_ready;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic [31:0] o_fire_cnt;

    ysyx_23060191_ifid dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_if_valid (i_if_valid),
        .o_if_ready (o_if_ready),
        .i_pc       (i_pc),
        .i_inst     (i_inst),
        .i_flush    (i_flush),
        .o_id_valid (o_id_valid),
        .i_id_ready (i_id_ready),
        .o_pc       (o_pc),
        .o_inst     (o_inst),
        .o_fire_cnt (o_fire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    pair_t       q[$];
    logic [31:0] m_cnt;
    bit          m_ready;
    bit          last_acc;
    bit          stall;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Fetch-side contract: a stalled offer must keep its PC/instruction.
    logic        hold_chk;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    initial hold_chk = 1'b0;
    always @(posedge clk) begin
        if (hold_chk && rstn) begin
            assert (i_pc == hold_pc && i_inst == hold_inst)
                else $error("fetch changed a stalled pair");
        end
        hold_chk  <= i_if_valid && !o_if_ready && !i_flush && rstn;
        hold_pc   <= i_pc;
        hold_inst <= i_inst;
    end

    // Called at a negedge with inputs already set: compare outputs, then advance the model.
    task automatic tick();
        bit exp_v;
        bit do_deq;
        bit do_enq;
        #1;
        exp_v = (q.size() > 0) && !i_flush;
        check("id_valid", {31'd0, o_id_valid}, {31'd0, exp_v});
        check("if_ready", {31'd0, o_if_ready}, {31'd0, m_ready});
        check("fire_cnt", o_fire_cnt, m_cnt);
        if (exp_v) begin
            check("pc", o_pc, q[0].pc);
            check("inst", o_inst, q[0].inst);
        end
        last_acc = i_if_valid && m_ready && !i_flush && rstn;
        stall    = i_if_valid && !m_ready && !i_flush && rstn;
        @(posedge clk);
        if (!rstn) begin
            q.delete();
            m_cnt   = 32'd0;
            m_ready = 1'b0;
        end else if (i_flush) begin
            q.delete();
            m_ready = 1'b1;
        end else begin
            do_deq = exp_v && i_id_ready;
            do_enq = i_if_valid && m_ready;
            if (do_deq) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 32'd1;
            end
            if (do_enq) q.push_back('{pc: i_pc, inst: i_inst});
            m_ready = (q.size() < 2);
        end
        @(negedge clk);
    endtask

    // Push n pairs with decode always ready, advancing the PC on each accept.
    task automatic stream(input int n);
        int sent;
        sent       = 0;
        i_id_ready = 1'b1;
        i_if_valid = 1'b1;
        for (int c = 0; c < 4 * n + 10 && sent < n; c++) begin
            tick();
            if (last_acc) begin
                sent++;
                i_pc   = i_pc + 32'd4;
                i_inst = $urandom;
            end
        end
        i_if_valid = 1'b0;
        check("stream_done", sent, n);
    endtask

    // Fill to two entries with decode stalled; leaves a third pair offered and held.
    task automatic fill_full();
        int acc;
        acc        = 0;
        i_id_ready = 1'b0;
        i_if_valid = 1'b1;
        for (int c = 0; c < 8 && acc < 2; c++) begin
            tick();
            if (last_acc) begin
                acc++;
                i_pc   = i_pc + 32'd4;
                i_inst = $urandom;
            end
        end
        check("fill_done", acc, 2);
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            if (!stall) begin
                if (last_acc) i_pc = i_pc + 32'd4;
                i_if_valid = ($urandom_range(0, 3) != 0);
                i_inst     = $urandom;
            end
            i_id_ready = ($urandom_range(0, 2) != 0);
            i_flush    = ($urandom_range(0, 11) == 0);
            tick();
        end
        i_flush    = 1'b0;
        i_if_valid = 1'b0;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        last_acc   = 1'b0;
        stall      = 1'b0;
        rstn       = 1'b0;
        i_if_valid = 1'b0;
        i_flush    = 1'b0;
        i_id_ready = 1'b0;
        i_pc       = 32'd0;
        i_inst     = 32'd0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        q.delete();
        m_cnt   = 32'd0;
        m_ready = 1'b0;
        check("rst_pc", o_pc, 32'd0);
        check("rst_inst", o_inst, 32'd0);
        check("rst_valid", {31'd0, o_id_valid}, 32'd0);
        check("rst_ready", {31'd0, o_if_ready}, 32'd0);
        check("rst_cnt", o_fire_cnt, 32'd0);

        // Streaming with decode always ready
        rstn   = 1'b1;
        i_pc   = 32'h8000_0000;
        i_inst = $urandom;
        stream(8);
        tick();
        tick();
        check("cnt_after_8", o_fire_cnt, 32'd8);

        // Decode stall: buffer fills, head held
        i_pc   = 32'h8000_0000;
        i_inst = 32'h0000_0013;
        fill_full();
        tick();
        tick();
        check("full_ready", {31'd0, o_if_ready}, 32'd0);
        check("full_head_pc", o_pc, 32'h8000_0000);
        check("full_head_inst", o_inst, 32'h0000_0013);
        i_if_valid = 1'b0;
        i_id_ready = 1'b1;
        repeat (4) tick();

        // Flush while full with both handshakes offered
        i_pc = 32'h8000_0040;
        fill_full();
        i_flush    = 1'b1;
        i_id_ready = 1'b1;
        tick();
        i_flush    = 1'b0;
        i_pc       = 32'h8000_0100;
        i_inst     = $urandom;
        tick();
        i_if_valid = 1'b0;
        check("flush_first_pc", o_pc, 32'h8000_0100);
        tick();
        tick();

        // Steady state: simultaneous enq/deq in ONE
        i_id_ready = 1'b0;
        i_if_valid = 1'b1;
        i_pc       = 32'h8000_0200;
        i_inst     = $urandom;
        tick();
        i_id_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            i_pc   = i_pc + 32'd4;
            i_inst = $urandom;
            tick();
        end
        i_if_valid = 1'b0;
        tick();
        tick();

        // Reset while full with a count of 5, then counter wrap
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        i_pc = 32'h8000_0300;
        stream(5);
        tick();
        tick();
        check("cnt_five", o_fire_cnt, 32'd5);
        fill_full();
        rstn = 1'b0;
        tick();
        check("rst2_pc", o_pc, 32'd0);
        check("rst2_inst", o_inst, 32'd0);
        check("rst2_cnt", o_fire_cnt, 32'd0);
        rstn       = 1'b1;
        i_if_valid = 1'b1;
        tick();
        tick();
        i_if_valid = 1'b0;
        force dut.fire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.fire_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        tick();
        i_id_ready = 1'b1;
        tick();
        check("cnt_wrap", o_fire_cnt, 32'd0);

        // Randomized traffic with stalls and flushes
        i_pc = 32'h8000_1000;
        rand_phase(400);
        i_id_ready = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
